// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared state type, width helpers and BCM timing for the scan controller
`timescale 1ns/1ps
package display_scan_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  localparam int DEF_COLUMNS     = 32;
  localparam int DEF_ROWS        = 16;
  localparam int DEF_BITWIDTH    = 8;
  localparam int DEF_PIPE_LENGTH = 1;
  localparam int DEF_OE_BASE     = 4;

  // Address width for an index range of n values; never narrower than one bit
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Step counter must reach columns + pipe_length - 1 without wrapping
  function automatic int step_w(input int columns, input int pipe_length);
    return addr_w(columns + pipe_length);
  endfunction

  // Holds the longest on-time (top plane) without overflow
  function automatic int oe_w(input int oe_base, input int bitwidth);
    return $clog2(oe_base << (bitwidth - 1)) + 1;
  endfunction

  // Binary-weighted on-time for a bit-plane
  function automatic int oe_cycles(input int oe_base, input int plane);
    return oe_base << plane;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - framebuffer, rgb pipe and panel signals of the scan controller
`timescale 1ns/1ps
interface display_scan_controller_if
  import display_scan_controller_pkg::*;
#(
  parameter int COLUMNS  = DEF_COLUMNS,
  parameter int ROWS     = DEF_ROWS,
  parameter int BITWIDTH = DEF_BITWIDTH
);
  localparam int COL_W   = addr_w(COLUMNS);
  localparam int ROW_W   = addr_w(ROWS);
  localparam int PLANE_W = addr_w(BITWIDTH);

  logic               enable;
  logic [COL_W-1:0]   mem_col;
  logic [ROW_W-1:0]   mem_row;
  logic               go;
  logic [PLANE_W-1:0] select;
  logic               panel_clk;
  logic               panel_latch;
  logic               panel_oe;
  logic [ROW_W-1:0]   panel_row;
  logic               frame_start;

  modport master (
    input  enable,
    output mem_col, mem_row, go, select,
    output panel_clk, panel_latch, panel_oe, panel_row, frame_start
  );

  modport slave (
    output enable,
    input  mem_col, mem_row, go, select,
    input  panel_clk, panel_latch, panel_oe, panel_row, frame_start
  );

endinterface

// File: rtl/display_bcm_timer.sv
// rtl/display_bcm_timer.sv - loadable down-counter timing one bit-plane on-time
`timescale 1ns/1ps
module display_bcm_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_cycles,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Count down from the loaded on-time; the counter rests at zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_cycles;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Done marks the last on cycle so the owner can leave on the next edge
  assign o_done = (r_count == CNT_W'(1));

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - row x bit-plane scan sequencer for a HUB75-style panel
`timescale 1ns/1ps
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int COLUMNS     = DEF_COLUMNS,
  parameter int ROWS        = DEF_ROWS,
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int PIPE_LENGTH = DEF_PIPE_LENGTH,
  parameter int OE_BASE     = DEF_OE_BASE
) (
  input logic                        clk,
  input logic                        rst,
  display_scan_controller_if.master  bus
);

  localparam int COL_W   = addr_w(COLUMNS);
  localparam int ROW_W   = addr_w(ROWS);
  localparam int PLANE_W = addr_w(BITWIDTH);
  localparam int STEP_W  = step_w(COLUMNS, PIPE_LENGTH);
  localparam int OE_W    = oe_w(OE_BASE, BITWIDTH);

  localparam logic [STEP_W-1:0]  LAST_STEP      = STEP_W'(COLUMNS + PIPE_LENGTH - 2);
  localparam logic [STEP_W-1:0]  LAST_COL_STEP  = STEP_W'(COLUMNS - 1);
  localparam logic [STEP_W-1:0]  FIRST_CLK_STEP = STEP_W'(PIPE_LENGTH - 1);
  localparam logic [COL_W-1:0]   MAX_COL        = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW       = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE     = PLANE_W'(BITWIDTH - 1);

  scan_state_t        r_state;
  logic [STEP_W-1:0]  r_step;
  logic               r_phase;
  logic [ROW_W-1:0]   r_row;
  logic [PLANE_W-1:0] r_plane;
  logic               r_go;
  logic               r_panel_clk;
  logic               r_panel_latch;
  logic               r_panel_oe;
  logic [ROW_W-1:0]   r_panel_row;
  logic               r_frame_start;
  logic [COL_W-1:0]   r_mem_col;
  logic [ROW_W-1:0]   r_mem_row;
  logic [PLANE_W-1:0] r_select;

  logic [STEP_W-1:0]  w_step_inc;
  logic               w_clk_step;
  logic               w_last_plane;
  logic               w_frame_end;
  logic [ROW_W-1:0]   w_next_row;
  logic [PLANE_W-1:0] w_next_plane;
  logic               w_timer_load;
  logic [OE_W-1:0]    w_timer_cycles;
  logic               w_timer_done;

  // Priming steps fill the rgb pipe without clocking the panel
  assign w_step_inc   = r_step + STEP_W'(1);
  assign w_clk_step   = (w_step_inc > FIRST_CLK_STEP);
  assign w_last_plane = (r_plane == LAST_PLANE);
  assign w_frame_end  = w_last_plane && (r_row == LAST_ROW);
  assign w_next_plane = w_last_plane ? '0 : r_plane + PLANE_W'(1);
  assign w_next_row   = !w_last_plane ? r_row :
                        (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);

  assign w_timer_load   = (r_state == LATCH);
  assign w_timer_cycles = OE_W'(oe_cycles(OE_BASE, int'(r_plane)));

  display_bcm_timer #(
    .CNT_W (OE_W)
  ) u_bcm_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timer_load),
    .i_cycles (w_timer_cycles),
    .o_done   (w_timer_done)
  );

  // Scan sequencer; every output is set on the edge entering the cycle it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_step        <= '0;
      r_phase       <= 1'b0;
      r_row         <= '0;
      r_plane       <= '0;
      r_go          <= 1'b0;
      r_panel_clk   <= 1'b0;
      r_panel_latch <= 1'b0;
      r_panel_oe    <= 1'b1;
      r_panel_row   <= '0;
      r_frame_start <= 1'b0;
      r_mem_col     <= '0;
      r_mem_row     <= '0;
      r_select      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state       <= SHIFT;
            r_step        <= '0;
            r_phase       <= 1'b0;
            r_row         <= '0;
            r_plane       <= '0;
            r_go          <= 1'b1;
            r_frame_start <= 1'b1;
            r_mem_col     <= '0;
            r_mem_row     <= '0;
            r_select      <= '0;
          end
        end
        SHIFT: begin
          if (!r_phase) begin
            // Phase A -> B: clock the panel once the pipe output is valid,
            // and present the address the next go will consume
            r_phase       <= 1'b1;
            r_go          <= 1'b0;
            r_frame_start <= 1'b0;
            r_panel_clk   <= w_clk_step;
            r_mem_col     <= (w_step_inc > LAST_COL_STEP) ? MAX_COL : w_step_inc[COL_W-1:0];
          end else begin
            r_panel_clk <= 1'b0;
            if (r_step == LAST_STEP) begin
              r_state <= BLANK;
            end else begin
              r_step  <= w_step_inc;
              r_phase <= 1'b0;
              r_go    <= 1'b1;
            end
          end
        end
        BLANK: begin
          r_state       <= LATCH;
          r_panel_latch <= 1'b1;
          r_panel_row   <= r_row;
        end
        LATCH: begin
          // Framebuffer address and plane for the following pass are set up
          // during DISPLAY so the first go of that pass sees valid read data
          r_state       <= DISPLAY;
          r_panel_latch <= 1'b0;
          r_panel_oe    <= 1'b0;
          r_mem_col     <= '0;
          r_mem_row     <= w_next_row;
          r_select      <= w_next_plane;
        end
        DISPLAY: begin
          if (w_timer_done) begin
            r_panel_oe <= 1'b1;
            r_row      <= w_next_row;
            r_plane    <= w_next_plane;
            r_step     <= '0;
            r_phase    <= 1'b0;
            if (w_frame_end && !bus.enable) begin
              r_state <= IDLE;
            end else begin
              r_state       <= SHIFT;
              r_go          <= 1'b1;
              r_frame_start <= w_frame_end;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_col     = r_mem_col;
  assign bus.mem_row     = r_mem_row;
  assign bus.go          = r_go;
  assign bus.select      = r_select;
  assign bus.panel_clk   = r_panel_clk;
  assign bus.panel_latch = r_panel_latch;
  assign bus.panel_oe    = r_panel_oe;
  assign bus.panel_row   = r_panel_row;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Sequencer feeding display_driver_rgb_pipe and driving the HUB75-style panel control lines.
- Walks rows × bit-planes. Per plane it:
  - issues framebuffer read addresses plus the pipe's go and select;
  - clocks columns into the panel;
  - latches the shifted data;
  - holds OE for a binary-weighted on-time (BCM).
- Sits between the framebuffer RAM (synchronous read, 1-cycle latency) and the rgb pipe / panel pins.

Parameters:
- columns, 32, pixels shifted per row per plane (≥2).
- rows, 16, scan rows (addressed rows, i.e. half-panel height for dual-segment panels).
- bitwidth, 8, bits per colour channel = number of bit-planes.
- pipe_length, 1, rgb pipe depth in go pulses (≥1).
- oe_base, 4, OE-on cycles for plane 0; plane b is on for oe_base << b cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  run scanning; sampled at frame boundaries.
- mem_col  output  $clog2(columns)  framebuffer column read address.
- mem_row  output  $clog2(rows)  framebuffer row read address.
- go  output  1  advance rgb pipe.
- select  output  $clog2(bitwidth)  bit-plane index to rgb pipe.
- panel_clk  output  1  panel shift clock; panel samples on rising edge.
- panel_latch  output  1  panel latch strobe, active-high.
- panel_oe  output  1  panel output enable, active-low.
- panel_row  output  $clog2(rows)  row address lines to panel.
- frame_start  output  1  one-cycle pulse at start of row 0, plane 0.

Behaviour:
- Reset (async, immediate): state IDLE.
  - panel_oe=1 (blanked); go=0, panel_clk=0, panel_latch=0, frame_start=0.
  - select=0, mem_col=0, mem_row=0, panel_row=0; internal counters 0.
- All outputs are registered. No combinational path from enable to outputs.
- IDLE: panel_oe=1. When enable=1 → SHIFT with row=0, plane=0; frame_start pulses in the first SHIFT cycle.
- SHIFT: two cycles per step, phase A then phase B.
  - mem_row = current row. mem_col = index of the next step. mem_col is stable ≥1 cycle before the go that consumes it.
  - Phase A: go=1, panel_clk=0.
  - Phase B: go=0, panel_clk=1, only when the step index is ≥ pipe_length-1; otherwise panel_clk stays 0.
  - Step count = columns + pipe_length - 1. The first pipe_length-1 steps prime the pipe. This gives exactly `columns` panel_clk pulses, each sampling column 0..columns-1 in order.
  - For flush steps (index ≥ columns), mem_col holds columns-1.
  - select = current plane for every go in the phase.
- BLANK: 1 cycle. panel_oe=1, panel_clk=0.
- LATCH: 1 cycle. panel_latch=1. panel_row updates to the current row in this same cycle (row change only while blanked).
- DISPLAY: panel_oe=0 for exactly oe_base << plane cycles; all other strobes 0.
- End of DISPLAY:
  - plane < bitwidth-1 → plane+1, go to SHIFT.
  - Otherwise plane=0 and row+1 (wraps rows-1 → 0), go to SHIFT.
  - At row wrap with enable=0 → IDLE instead (panel_oe=1 the next cycle).
- enable is sampled only at the frame boundary. Deasserting it mid-frame finishes the current frame.
- Counter widths:
  - Column/step counter: $clog2(columns+pipe_length).
  - OE counter: $clog2(oe_base<<(bitwidth-1))+1. No overflow at the max plane.
- panel_oe is never 0 in the same cycle as panel_latch=1 or panel_clk=1.
- rst asserted mid-SHIFT/DISPLAY: immediate blank (panel_oe=1). Restart from row 0, plane 0 after release, provided enable=1.
- Frame period (cycles) = rows × Σ_b [2(columns+pipe_length-1) + 2 + (oe_base<<b)].

Decomposition:
- Shared package:
  - state enum: IDLE, SHIFT, BLANK, LATCH, DISPLAY;
  - localparam width helpers (col/row/plane/oe counter widths);
  - BCM on-time function oe_cycles(plane).
- One natural sub-module: display_bcm_timer. It is a loadable down-counter for oe_base << plane with a done pulse; it is reusable for a future overlapped-shift variant.
- Everything else stays in one FSM.

Test Plan:
- Reset/idle: rst=1 then 0, enable=0 for 100 cycles → panel_oe=1, go=0, panel_clk=0, panel_latch=0 throughout.
- Single plane, columns=4, pipe_length=1, oe_base=2:
  - Stimulus: enable=1, bench RAM returns pixel = column index.
  - Required: exactly 4 panel_clk pulses; rgb at each rising panel_clk matches column 0,1,2,3.
  - Required: latch 1 cycle after BLANK; plane 0 OE low for exactly 2 cycles.
- Pipe priming, pipe_length=3, columns=4:
  - Required: 6 go pulses per plane, 4 panel_clk pulses, first panel_clk on the 3rd go step.
  - Required: panel data equals columns 0..3 in order.
- BCM weights, bitwidth=4, oe_base=4: OE low durations per row are 4, 8, 16, 32; select is 0..3 in sequence for the matching SHIFT phases.
- Row wrap/stop, rows=2:
  - Required: panel_row steps 0,1,0 and changes only in LATCH cycles.
  - Required: frame_start pulses once per frame.
  - Stimulus: drop enable mid-frame → frame completes, then IDLE with panel_oe=1.
- Async reset mid-DISPLAY: assert rst between clock edges → panel_oe=1 immediately without a clock edge. After release, frame_start fires and panel_row=0.
